// File: rtl/daf_pkg.sv
// Shared types and defaults for the DAF audio front end.
package daf_pkg;

    localparam int SAMPLE_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE,
        LEFT,
        RIGHT
    } i2s_state_t;

endpackage

// File: rtl/i2s_sync.sv
// Two-flop synchroniser for sck/ws/sd with a registered sck rise strobe.
module i2s_sync (
    input  logic clk,
    input  logic n_rst,
    input  logic sck,
    input  logic ws,
    input  logic sd,
    output logic ws_s,
    output logic sd_s,
    output logic sck_rise
);

    logic [1:0] sck_q;
    logic [1:0] ws_q;
    logic [1:0] sd_q;
    logic       sck_d;

    // ws/sd get a third stage too, so they stay aligned with the rise strobe
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sck_q    <= '0;
            ws_q     <= '0;
            sd_q     <= '0;
            sck_d    <= 1'b0;
            sck_rise <= 1'b0;
            ws_s     <= 1'b0;
            sd_s     <= 1'b0;
        end else begin
            sck_q    <= {sck_q[0], sck};
            ws_q     <= {ws_q[0], ws};
            sd_q     <= {sd_q[0], sd};
            sck_d    <= sck_q[1];
            sck_rise <= sck_q[1] & ~sck_d;
            ws_s     <= ws_q[1];
            sd_s     <= sd_q[1];
        end
    end

endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: deserialises left/right words into one stereo frame
// per sample period, with short-word detection.
module i2s_rx
    import daf_pkg::*;
#(
    parameter int SAMPLE_W = SAMPLE_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  en,
    input  logic                  sck,
    input  logic                  ws,
    input  logic                  serial_data_in,
    output logic [2*SAMPLE_W-1:0] parallel_i2s,
    output logic                  frame_valid,
    output logic                  len_err
);

    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam int CNT_W   = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(SAMPLE_W);

    logic                ws_s;
    logic                sd_s;
    logic                sck_rise;
    logic                ws_prev;
    logic                boundary;
    logic                short_word;
    logic [CNT_W-1:0]    bit_cnt;
    logic [CNT_W-1:0]    cnt_nxt;
    logic [SAMPLE_W-1:0] shifter;
    logic [SAMPLE_W-1:0] shift_nxt;
    logic [SAMPLE_W-1:0] word;
    logic [SAMPLE_W-1:0] left_hold;
    i2s_state_t          state;

    i2s_sync u_sync (
        .clk      (clk),
        .n_rst    (n_rst),
        .sck      (sck),
        .ws       (ws),
        .sd       (serial_data_in),
        .ws_s     (ws_s),
        .sd_s     (sd_s),
        .sck_rise (sck_rise)
    );

    // The boundary bit is the LSB of the closing word, so it is shifted
    // in before the word is left-justified.
    always_comb begin
        shift_nxt = shifter;
        cnt_nxt   = bit_cnt;
        if (bit_cnt < FULL) begin
            shift_nxt = {shifter[SAMPLE_W-2:0], sd_s};
            cnt_nxt   = bit_cnt + CNT_W'(1);
        end
        word       = shift_nxt << (FULL - cnt_nxt);
        boundary   = ws_s != ws_prev;
        short_word = cnt_nxt < FULL;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state        <= IDLE;
            ws_prev      <= 1'b0;
            bit_cnt      <= '0;
            shifter      <= '0;
            left_hold    <= '0;
            parallel_i2s <= '0;
            frame_valid  <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            len_err     <= 1'b0;
            if (sck_rise) begin
                ws_prev <= ws_s;
            end
            if (!en) begin
                state   <= IDLE;
                shifter <= '0;
                bit_cnt <= '0;
            end else if (sck_rise) begin
                if (boundary || state == IDLE) begin
                    shifter <= '0;
                    bit_cnt <= '0;
                end else begin
                    shifter <= shift_nxt;
                    bit_cnt <= cnt_nxt;
                end
                case (state)
                    IDLE: begin
                        if (boundary && !ws_s) begin
                            state <= LEFT;
                        end
                    end
                    LEFT: begin
                        if (boundary) begin
                            left_hold <= word;
                            len_err   <= short_word;
                            state     <= RIGHT;
                        end
                    end
                    RIGHT: begin
                        if (boundary) begin
                            parallel_i2s <= FRAME_W'({left_hold, word});
                            frame_valid  <= 1'b1;
                            len_err      <= short_word;
                            state        <= LEFT;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2s_rx.sv
// Randomised I2S stream against a word-level reference model.
module tb_i2s_rx;

    logic        clk = 1'b0;
    logic        n_rst = 1'b0;
    logic        en = 1'b1;
    logic        sck = 1'b0;
    logic        ws = 1'b1;
    logic        sd = 1'b0;
    logic [31:0] par;
    logic        fv;
    logic        le;

    i2s_rx #(.SAMPLE_W(16)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .en             (en),
        .sck            (sck),
        .ws             (ws),
        .serial_data_in (sd),
        .parallel_i2s   (par),
        .frame_valid    (fv),
        .len_err        (le)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          f;
        bit          e;
        logic [31:0] d;
        int          c;
    } ev_t;

    ev_t         q[$];
    ev_t         ev;
    int          nvec = 0;
    int          nerr = 0;
    int          per = 8;
    bit          cur_ch = 1'b1;
    int          mst = 0;
    bit          dis = 1'b0;
    logic [15:0] hold = '0;
    logic [31:0] last = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    // Left-justify a word of n bits into 16, truncating long words
    function automatic logic [15:0] pad(input logic [31:0] v, input int n);
        if (n >= 16) return 16'(v >> (n - 16));
        return 16'(v << (16 - n));
    endfunction

    // Word-level model: frames start after a right->left change seen in sync
    task automatic model_lsb(input logic [31:0] v, input int n,
                             input bit c, input bit nc, input int rc);
        logic [15:0] w = pad(v, n);
        bit          s = (n < 16);
        if (dis) mst = 0;
        dis = 1'b0;
        case (mst)
            0: if (c && !nc) mst = 1;
            1: begin
                hold = w;
                if (s) q.push_back('{1'b0, 1'b1, 32'h0, rc + 4});
                mst = 2;
            end
            default: begin
                q.push_back('{1'b1, s, {hold, w}, rc + 4});
                mst = 1;
            end
        endcase
    endtask

    task automatic disrupt(input int kind);
        if (kind == 1) begin
            en = 1'b0;
            repeat (2) @(posedge clk);
            #1 en = 1'b1;
        end else begin
            n_rst = 1'b0;
            #1;
            check("rst_par", par, 32'h0);
            check("rst_fv", {31'h0, fv}, 32'h0);
            check("rst_le", {31'h0, le}, 32'h0);
            last = '0;
            repeat (2) @(posedge clk);
            #1 n_rst = 1'b1;
        end
        dis = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] v, input int n,
                             input int act, input int act_bit);
        bit c = cur_ch;
        bit nc = ~cur_ch;
        for (int i = n - 1; i >= 0; i--) begin
            sck = 1'b0;
            ws  = (i == 0) ? nc : c;
            sd  = v[i];
            repeat (per / 2) @(posedge clk);
            #1 sck = 1'b1;
            if (i == 0) model_lsb(v, n, c, nc, cyc);
            repeat (per / 2) @(posedge clk);
            #1;
            if (i == act_bit) disrupt(act);
        end
        cur_ch = nc;
    endtask

    task automatic rnd_frames(input int cnt, input bit vary);
        for (int k = 0; k < cnt; k++) begin
            int nl = vary ? int'($urandom_range(10, 20)) : 16;
            int nr = vary ? int'($urandom_range(10, 20)) : 16;
            if (vary) per = 2 * int'($urandom_range(2, 4));
            send_word($urandom, nl, 0, -1);
            send_word($urandom, nr, 0, -1);
        end
    endtask

    always @(negedge clk) begin
        if (n_rst) begin
            if (fv || le) begin
                if (q.size() == 0) begin
                    check("spurious", {30'h0, fv, le}, 32'h0);
                end else begin
                    ev = q.pop_front();
                    check("fv", {31'h0, fv}, {31'h0, ev.f});
                    check("len_err", {31'h0, le}, {31'h0, ev.e});
                    check("latency", cyc, ev.c);
                    if (ev.f) begin
                        check("frame", par, ev.d);
                        last = ev.d;
                    end
                end
            end
            if (!fv) check("hold", par, last);
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("init_par", par, 32'h0);
        check("init_fv", {31'h0, fv}, 32'h0);
        check("init_le", {31'h0, le}, 32'h0);
        n_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        // nominal: sync word, dummy frame, then the reference frame
        send_word($urandom, 16, 0, -1);
        rnd_frames(1, 1'b0);
        send_word(32'hA5C3, 16, 0, -1);
        send_word(32'h1234, 16, 0, -1);
        // reset released seven bits into a right word
        send_word($urandom, 16, 0, -1);
        send_word($urandom, 16, 2, 9);
        rnd_frames(2, 1'b0);
        // short left, then long right
        send_word(32'hABC, 12, 0, -1);
        send_word(32'h0F0F, 16, 0, -1);
        send_word($urandom, 16, 0, -1);
        send_word(32'hFEDCB, 20, 0, -1);
        // reset mid-left word
        send_word($urandom, 16, 2, 8);
        send_word($urandom, 16, 0, -1);
        rnd_frames(2, 1'b0);
        // enable dropped mid-left word
        send_word($urandom, 16, 1, 5);
        send_word($urandom, 16, 0, -1);
        rnd_frames(1, 1'b0);
        // back-to-back at the fastest bit clock
        per = 4;
        rnd_frames(4, 1'b0);
        rnd_frames(6, 1'b1);
        sck = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("pending", q.size(), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/i2s_rx.md
Name: i2s_rx

Overview:
- Upstream front end of the DAF effects chain. Deserialises the external codec's I2S stream (sck, ws, serial_data_in) into one parallel stereo frame per sample period.
- The frame feeds the flanger, amp clip, amp comp and fader path.
- Runs on the fast system clock. sck and ws are asynchronous inputs that the block synchronises and edge-detects itself.

Parameters:
- SAMPLE_W, 16, bits per channel word. Frame width is 2*SAMPLE_W (localparam).

Ports:
- clk  in  1  system clock, at least 4x the sck frequency
- n_rst  in  1  asynchronous active-low reset
- en  in  1  receiver enable; low forces IDLE
- sck  in  1  I2S bit clock (asynchronous)
- ws  in  1  I2S word select: 0 = left, 1 = right (asynchronous)
- serial_data_in  in  1  I2S data, MSB first, changes on sck falling edge
- parallel_i2s  out  2*SAMPLE_W  {left, right}; left in the upper half
- frame_valid  out  1  single-cycle pulse when parallel_i2s updates
- len_err  out  1  single-cycle pulse: word shorter than SAMPLE_W bits

Behaviour:
- Reset: parallel_i2s = 0, frame_valid = 0, len_err = 0, state = IDLE, counters and shift register = 0.
- Synchronisation: sck, ws and serial_data_in each pass through an identical 2-flop synchroniser, so they stay mutually aligned. A third sck flop gives rise detection. All logic below acts only in the clk cycle where a synchronised sck rising edge is detected ("bit event").
- At each bit event:
  - Sample sd_s and ws_s.
  - If bit_cnt < SAMPLE_W: shift sd_s in at the LSB and increment bit_cnt. Otherwise ignore the bit (bit_cnt saturates).
  - ws_prev <= ws_s.
- Word boundary: a bit event with ws_s != ws_prev. Per I2S, the bit sampled at that event is the LSB of the word just ending, so it is included before the word closes. The closed word is shifter << (SAMPLE_W - bit_cnt_after_shift), i.e. left-justified and zero-padded. bit_cnt then clears to 0.
- States:
  - IDLE: shifting is discarded. A ws 1->0 boundary moves to LEFT. No output is produced, so a partial first frame is never emitted.
  - LEFT: a 0->1 boundary latches the left word into a holding register and moves to RIGHT.
  - RIGHT: a 1->0 boundary writes parallel_i2s = {left_hold, right_word} and moves to LEFT. frame_valid is high for exactly the next clk cycle.
- Latency: parallel_i2s and frame_valid update 1 clk after the bit event carrying the right LSB. That is 4 clk after the raw sck rise (2 sync + 1 edge + 1 register).
- len_err: pulses alongside the boundary-cycle update when the closing word had fewer than SAMPLE_W bits. The word is still stored, padded.
- Long word (more than SAMPLE_W bits): the top SAMPLE_W bits are kept, with no error.
- parallel_i2s holds its value between frames. There is no backpressure; the consumer must take the frame within one sample period.
- en low: the next clk enters IDLE and clears the shifter and bit_cnt. parallel_i2s keeps its value. A pending frame_valid is not generated.
- Reset mid-frame: the asynchronous clear returns everything to the reset values. Resynchronisation needs the next ws 1->0 edge.
- Simultaneous boundary and en falling: en wins; no frame_valid.

Decomposition:
- daf_pkg holds:
  - the SAMPLE_W default constant
  - the i2s_state_t enum {IDLE, LEFT, RIGHT}
- One sub-module, i2s_sync: a 3-input 2-flop synchroniser plus sck rise detector. It outputs ws_s, sd_s and sck_rise.

Test Plan:
- Nominal: sck period 8 clk, en = 1, one dummy frame, then left 16'hA5C3 and right 16'h1234. Expect parallel_i2s = 32'hA5C3_1234 with frame_valid high for one cycle, 4 clk after the right-LSB sck rise, and len_err = 0.
- Start-up mid-frame: release reset while ws = 1 and 7 bits into a right word. Expect no frame_valid until the first complete left+right pair. The first frame equals the sent values, with no garbage frame.
- Short word: left word of 12 bits, 12'hABC. Expect upper half 16'hABC0 and a len_err pulse on the 0->1 boundary cycle. A following 16-bit right 16'h0F0F is stored intact.
- Long word: 20-bit right word 20'hFEDCB. Expect lower half 16'hFEDC and len_err = 0.
- Reset and enable: assert n_rst low mid-left-word. Expect all outputs 0 immediately (asynchronously). Separately, drop en for 2 cycles mid-frame. Expect no frame_valid for that frame, parallel_i2s unchanged, and the next full frame received correctly.
- Back-to-back frames: 4 consecutive frames with sck period 4 clk (the minimum). Expect 4 frame_valid pulses, each with its correct data, and none missed.
